// File: rtl/rf_wb_arbiter_if.sv
// Writeback-arbiter bus bundle.
// Groups the requester handshake, the registered regfile write command, the issue-side
// scoreboard update and the scoreboard output.
//   req_valid/req_id/req_data : per-requester write requests (requester -> arbiter)
//   req_ready                 : per-requester grant (arbiter -> requester)
//   wr_valid/wr_id/wr_data    : registered regfile write command (arbiter -> regfile)
//   issue_valid/id/src        : destination being issued and its producing requester
//   busy                      : per-register pending-write scoreboard
interface rf_wb_arbiter_if #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned CREG_NUM = 32,
  parameter int unsigned ID_W     = 5,
  parameter int unsigned SRC_W    = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][ID_W-1:0] req_id;
  logic [NREQ-1:0][31:0]     req_data;
  logic [NREQ-1:0]           req_ready;

  logic                      wr_valid;
  logic [ID_W-1:0]           wr_id;
  logic [31:0]               wr_data;

  logic                      issue_valid;
  logic [ID_W-1:0]           issue_id;
  logic [SRC_W-1:0]          issue_src;

  logic [CREG_NUM-1:0]       busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_id, req_data, issue_valid, issue_id, issue_src,
    output req_ready, wr_valid, wr_id, wr_data, busy
  );

  // Requester / issue / regfile side.
  modport master (
    output req_valid, req_id, req_data, issue_valid, issue_id, issue_src,
    input  req_ready, wr_valid, wr_id, wr_data, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a pending-write
// scoreboard with owner tags for RAW stall detection.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   io_bus : rf_wb_arbiter_if.slave -- requests in, grants out, registered write command
//            out, issue updates in, busy scoreboard out
module rf_wb_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned CREG_NUM = 32,
  parameter int unsigned ID_W     = 5,
  parameter int unsigned SRC_W    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  rf_wb_arbiter_if.slave       io_bus
);

  logic [SRC_W-1:0]                r_rr;
  logic                            r_wr_valid;
  logic [ID_W-1:0]                 r_wr_id;
  logic [31:0]                     r_wr_data;
  logic [SRC_W-1:0]                r_wr_src;
  logic [CREG_NUM-1:0]             r_busy;
  logic [CREG_NUM-1:0][SRC_W-1:0]  r_owner;

  logic [NREQ-1:0]                 w_grant;
  logic [SRC_W-1:0]                w_gidx;
  logic [SRC_W-1:0]                w_scan;
  logic                            w_found;
  logic [SRC_W-1:0]                w_rr_next;
  logic [ID_W-1:0]                 w_sel_id;
  logic [31:0]                     w_sel_data;

  // Scan from r_rr upward, wrapping; the first valid requester wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_scan  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_scan = SRC_W'((k + 32'(r_rr)) % NREQ);
      if (!w_found && io_bus.req_valid[w_scan]) begin
        w_found         = 1'b1;
        w_grant[w_scan] = 1'b1;
        w_gidx          = w_scan;
      end
    end
  end

  always_comb begin
    w_rr_next  = (w_gidx == SRC_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    w_sel_id   = io_bus.req_id[w_gidx];
    w_sel_data = io_bus.req_data[w_gidx];
  end

  // Pointer and write stage. A grant to r0 is consumed but never reaches the regfile.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr       <= '0;
      r_wr_valid <= 1'b0;
      r_wr_id    <= '0;
      r_wr_data  <= '0;
      r_wr_src   <= '0;
    end else begin
      r_wr_valid <= w_found && (w_sel_id != '0);
      if (w_found) begin
        r_rr      <= w_rr_next;
        r_wr_id   <= w_sel_id;
        r_wr_data <= w_sel_data;
        r_wr_src  <= w_gidx;
      end
    end
  end

  // Scoreboard. Only the most recent issuer of a register may clear it, so a late write
  // from a superseded producer leaves the hazard in place. Issue beats clear on the same
  // register at the same edge. Register 0 never becomes busy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy  <= '0;
      r_owner <= '0;
    end else begin
      for (int unsigned i = 0; i < CREG_NUM; i++) begin
        if (i != 0 && io_bus.issue_valid && io_bus.issue_id == ID_W'(i)) begin
          r_busy[i]  <= 1'b1;
          r_owner[i] <= io_bus.issue_src;
        end else if (i != 0 && r_wr_valid && r_wr_id == ID_W'(i) &&
                     r_wr_src == r_owner[i] && r_busy[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign io_bus.req_ready = w_grant;
  assign io_bus.wr_valid  = r_wr_valid;
  assign io_bus.wr_id     = r_wr_id;
  assign io_bus.wr_data   = r_wr_data;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a reference model predicts grants, the write
// stream (queued per cycle and popped after each edge) and the busy scoreboard.
module tb_rf_wb_arbiter;
  localparam int unsigned NREQ     = 3;
  localparam int unsigned CREG_NUM = 32;
  localparam int unsigned ID_W     = 5;
  localparam int unsigned SRC_W    = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  rf_wb_arbiter_if #(.NREQ(NREQ), .CREG_NUM(CREG_NUM), .ID_W(ID_W), .SRC_W(SRC_W)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .CREG_NUM(CREG_NUM), .ID_W(ID_W), .SRC_W(SRC_W)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Requester and issue stimulus state.
  logic [NREQ-1:0]  v;
  logic [ID_W-1:0]  rid   [NREQ];
  logic [31:0]      rdata [NREQ];
  bit               sticky;
  logic             iv;
  logic [ID_W-1:0]  iid;
  logic [SRC_W-1:0] isrc;

  // Reference model state.
  int                  m_rr;
  bit                  m_wv;
  logic [ID_W-1:0]     m_wid;
  int                  m_wsrc;
  logic [CREG_NUM-1:0] m_busy;
  int                  m_owner [CREG_NUM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_rr   = 0;
    m_wv   = 1'b0;
    m_wid  = '0;
    m_wsrc = 0;
    m_busy = '0;
    for (int i = 0; i < CREG_NUM; i++) m_owner[i] = 0;
    exp_q.delete();
  endtask

  task automatic apply_inputs();
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_id[i]   = rid[i];
      bus.req_data[i] = rdata[i];
    end
    bus.issue_valid = iv;
    bus.issue_id    = iid;
    bus.issue_src   = isrc;
  endtask

  // One clock: drive, check grant, predict, cross the edge, check write and scoreboard.
  task automatic step();
    int                  g;
    int                  idx;
    logic [NREQ-1:0]     eg;
    exp_t                e;
    exp_t                got;
    logic [CREG_NUM-1:0] nb;
    apply_inputs();
    #1;
    g  = -1;
    eg = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    e = '0;
    if (g >= 0) begin
      eg[g]  = 1'b1;
      e.v    = (rid[g] != '0);
      e.id   = rid[g];
      e.data = rdata[g];
    end
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    exp_q.push_back(e);
    nb = m_busy;
    for (int i = 1; i < CREG_NUM; i++) begin
      if (iv && iid == ID_W'(i)) begin
        nb[i]      = 1'b1;
        m_owner[i] = int'(isrc);
      end else if (m_wv && m_wid == ID_W'(i) && m_wsrc == m_owner[i] && m_busy[i]) begin
        nb[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_busy = nb;
    m_wv   = e.v;
    if (g >= 0) begin
      m_rr   = (g + 1) % NREQ;
      m_wid  = rid[g];
      m_wsrc = g;
      if (!sticky) v[g] = 1'b0;
    end
    iv = 1'b0;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL exp_queue: observed empty expected entry");
    end else begin
      got = exp_q.pop_front();
      chk("wr_valid", 32'(bus.wr_valid), 32'(got.v));
      if (got.v) begin
        chk("wr_id", 32'(bus.wr_id), 32'(got.id));
        chk("wr_data", bus.wr_data, got.data);
      end
    end
    chk("busy", bus.busy, m_busy);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    v      = '0;
    iv     = 1'b0;
    sticky = 1'b0;
    apply_inputs();
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("rst_wr_id", 32'(bus.wr_id), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
  endtask

  initial begin
    v    = '0;
    iv   = 1'b0;
    iid  = '0;
    isrc = '0;
    for (int i = 0; i < NREQ; i++) begin
      rid[i]   = '0;
      rdata[i] = '0;
    end
    do_reset();

    // Single request from requester 1.
    v[1] = 1'b1; rid[1] = 5'd5; rdata[1] = 32'hDEADBEEF;
    step();
    step();
    // rr should now be 2: with all valid, requester 2 wins.
    v = '1; rid[0] = 5'd10; rid[1] = 5'd11; rid[2] = 5'd12;
    rdata[0] = 32'h0000_0A0A; rdata[1] = 32'h0000_0B0B; rdata[2] = 32'h0000_0C0C;
    step();
    v = '0;
    step();

    // Contention from reset: grants 0,1,2,0,... with back-to-back writes.
    do_reset();
    sticky = 1'b1;
    v = '1; rid[0] = 5'd1; rid[1] = 5'd2; rid[2] = 5'd3;
    rdata[0] = 32'h1111_0001; rdata[1] = 32'h2222_0002; rdata[2] = 32'h3333_0003;
    for (int n = 0; n < 6; n++) step();
    sticky = 1'b0;
    v = '0;
    step();

    // Register zero: accepted, advances rr, no write; issue to r0 ignored.
    do_reset();
    v[0] = 1'b1; rid[0] = 5'd0; rdata[0] = 32'h0000_1234;
    iv = 1'b1; iid = 5'd0; isrc = 2'd1;
    step();
    v = '1; rid[0] = 5'd20; rid[1] = 5'd21; rid[2] = 5'd22;
    step();
    v = '0;
    step();

    // Scoreboard set and owner-matched clear.
    iv = 1'b1; iid = 5'd7; isrc = 2'd2;
    step();
    v[2] = 1'b1; rid[2] = 5'd7; rdata[2] = 32'hCAFE_0007;
    step();
    step();
    step();

    // Ownership: a superseded producer must not clear.
    iv = 1'b1; iid = 5'd4; isrc = 2'd0;
    step();
    iv = 1'b1; iid = 5'd4; isrc = 2'd1;
    step();
    v[0] = 1'b1; rid[0] = 5'd4; rdata[0] = 32'h0000_0400;
    step();
    step();
    step();
    v[1] = 1'b1; rid[1] = 5'd4; rdata[1] = 32'h0000_0401;
    step();
    step();
    step();

    // Same-edge set and clear on r9: set wins and ownership moves to requester 1.
    iv = 1'b1; iid = 5'd9; isrc = 2'd0;
    step();
    v[0] = 1'b1; rid[0] = 5'd9; rdata[0] = 32'h0000_0900;
    step();
    iv = 1'b1; iid = 5'd9; isrc = 2'd1;
    step();
    step();
    v[0] = 1'b1; rid[0] = 5'd9; rdata[0] = 32'h0000_0901;
    step();
    step();
    step();
    v[1] = 1'b1; rid[1] = 5'd9; rdata[1] = 32'h0000_0902;
    step();
    step();
    step();

    // Asynchronous reset mid-burst.
    sticky = 1'b1;
    v = '1; rid[0] = 5'd13; rid[1] = 5'd14; rid[2] = 5'd15;
    iv = 1'b1; iid = 5'd13; isrc = 2'd0;
    step();
    iv = 1'b1; iid = 5'd14; isrc = 2'd1;
    step();
    #3;
    resetn = 1'b0;
    #1;
    chk("async_wr_valid", 32'(bus.wr_valid), 32'd0);
    chk("async_busy", bus.busy, 32'd0);
    model_reset();
    sticky = 1'b0;
    v = '0;
    apply_inputs();
    @(posedge clk);
    #1;
    chk("held_rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    #2;
    resetn = 1'b1;
    v = '1;
    step();
    step();
    v = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
